// File: rtl/tarea1_mem_pkg.sv
// Shared types and constants for the tarea1 Avalon-MM copy/fill master.
package tarea1_mem_pkg;

  localparam int         WORD_BYTES = 4;
  localparam logic [3:0] BE_ALL     = 4'hF;

  localparam int CMD_ADDR_W = 12;
  localparam int CMD_DATA_W = 32;
  localparam int CMD_LEN_W  = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic                  fill;
    logic [CMD_ADDR_W-1:0] src;
    logic [CMD_ADDR_W-1:0] dst;
    logic [CMD_LEN_W-1:0]  len;
    logic [CMD_DATA_W-1:0] pattern;
  } cmd_t;

endpackage

// File: rtl/tarea1_mem_copy_master.sv
// Avalon-MM master that copies a block of words or fills it with a pattern,
// one command at a time, with at most one read outstanding.
module tarea1_mem_copy_master
  import tarea1_mem_pkg::*;
#(
  parameter int ADDR_W = CMD_ADDR_W,
  parameter int DATA_W = CMD_DATA_W,
  parameter int LEN_W  = CMD_LEN_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_fill,
  input  logic [ADDR_W-1:0]   cmd_src,
  input  logic [ADDR_W-1:0]   cmd_dst,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic [DATA_W-1:0]   cmd_pattern,
  output logic                busy,
  output logic                done,
  output logic [LEN_W-1:0]    words_done,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid
);

  localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(WORD_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORD_BYTES - 1);

  state_e            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [LEN_W-1:0]  words_q, words_d;

  // Command src/dst fields double as the running read/write pointers.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    wdata_d = wdata_q;
    words_d = words_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          cmd_d.fill    = cmd_fill;
          cmd_d.src     = cmd_src & ALIGN_MASK;
          cmd_d.dst     = cmd_dst & ALIGN_MASK;
          cmd_d.len     = cmd_len;
          cmd_d.pattern = cmd_pattern;
          words_d       = '0;
          if (cmd_len == '0)  state_d = ST_DONE;
          else if (cmd_fill)  state_d = ST_WR_REQ;
          else                state_d = ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        if (!avm_waitrequest) begin
          cmd_d.src = cmd_q.src + ADDR_STEP;
          if (avm_readdatavalid) begin
            wdata_d = avm_readdata;
            state_d = ST_WR_REQ;
          end else begin
            state_d = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        if (avm_readdatavalid) begin
          wdata_d = avm_readdata;
          state_d = ST_WR_REQ;
        end
      end
      ST_WR_REQ: begin
        if (!avm_waitrequest) begin
          cmd_d.dst = cmd_q.dst + ADDR_STEP;
          words_d   = words_q + 1'b1;
          if (words_d == cmd_q.len) state_d = ST_DONE;
          else if (!cmd_q.fill)     state_d = ST_RD_REQ;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      words_q <= words_d;
    end
  end

  // Datapath registers are only observed through state-gated outputs.
  always_ff @(posedge clk) begin
    cmd_q   <= cmd_d;
    wdata_q <= wdata_d;
  end

  always_comb begin
    avm_read      = 1'b0;
    avm_write     = 1'b0;
    avm_address   = '0;
    avm_writedata = '0;
    case (state_q)
      ST_RD_REQ: begin
        avm_read    = 1'b1;
        avm_address = cmd_q.src;
      end
      ST_WR_REQ: begin
        avm_write     = 1'b1;
        avm_address   = cmd_q.dst;
        avm_writedata = cmd_q.fill ? cmd_q.pattern : wdata_q;
      end
      default: ;
    endcase
  end

  assign avm_byteenable = {(DATA_W/32){BE_ALL}};
  assign cmd_ready      = (state_q == ST_IDLE);
  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_DONE);
  assign words_done     = words_q;

endmodule

// File: tb/tb_tarea1_mem_copy_master.sv
// Scoreboard bench for tarea1_mem_copy_master against a latency-1 RAM slave.
module tb_tarea1_mem_copy_master;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 11;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              cmd_valid, cmd_ready, cmd_fill;
  logic [ADDR_W-1:0] cmd_src, cmd_dst;
  logic [LEN_W-1:0]  cmd_len;
  logic [DATA_W-1:0] cmd_pattern;
  logic              busy, done;
  logic [LEN_W-1:0]  words_done;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read, avm_write;
  logic [DATA_W-1:0] avm_writedata;
  logic [3:0]        avm_byteenable;
  logic              avm_waitrequest;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_readdatavalid;

  tarea1_mem_copy_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_fill(cmd_fill),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_pattern(cmd_pattern),
    .busy(busy), .done(done), .words_done(words_done),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] mem[1024];
  logic [31:0] ref_mem[1024];
  logic        mem_init = 1'b0;
  int n_cmp = 0, n_bad = 0;
  int rd_total = 0, wr_total = 0, rd_stall_cyc = 0, wr_stall_cyc = 0;
  int stall_rd_at = -1, stall_rd_until = 0, stall_wr_at = -1, stall_wr_until = 0;
  int done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    if (i < 3) return 32'h11111111 * (i + 1);
    return 32'hA5000000 | i;
  endfunction

  always_comb begin
    avm_waitrequest = 1'b0;
    if (avm_read && rd_total == stall_rd_at && rd_stall_cyc < stall_rd_until)
      avm_waitrequest = 1'b1;
    if (avm_write && wr_total == stall_wr_at && wr_stall_cyc < stall_wr_until)
      avm_waitrequest = 1'b1;
  end

  // RAM slave: read latency 1, writes land on acceptance.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
      mem_init <= 1'b1;
    end else if (avm_write && !avm_waitrequest) begin
      mem[avm_address[11:2]] <= avm_writedata;
    end
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avm_readdatavalid <= 1'b0;
    end else begin
      avm_readdatavalid <= 1'b0;
      if (avm_read && !avm_waitrequest) begin
        avm_readdatavalid <= 1'b1;
        avm_readdata      <= mem[avm_address[11:2]];
        rd_total          <= rd_total + 1;
      end
      if (avm_read && avm_waitrequest)   rd_stall_cyc <= rd_stall_cyc + 1;
      if (avm_write && !avm_waitrequest) wr_total <= wr_total + 1;
      if (avm_write && avm_waitrequest)  wr_stall_cyc <= wr_stall_cyc + 1;
    end
  end

  logic              prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr;
  logic              prev_rd, prev_wr;
  logic [DATA_W-1:0] prev_wd;

  always @(negedge clk) begin
    wr_t e;
    if (avm_read || avm_write) check("rw_exclusive", 32'(avm_read & avm_write), 0);
    if (prev_stall) begin
      check("stall_addr",  32'(avm_address), 32'(prev_addr));
      check("stall_read",  32'(avm_read),    32'(prev_rd));
      check("stall_write", 32'(avm_write),   32'(prev_wr));
      check("stall_wdata", avm_writedata,    prev_wd);
    end
    prev_stall <= (avm_read || avm_write) && avm_waitrequest && reset_n;
    prev_addr  <= avm_address;
    prev_rd    <= avm_read;
    prev_wr    <= avm_write;
    prev_wd    <= avm_writedata;
    if (avm_write && !avm_waitrequest) begin
      check("wr_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(avm_address), 32'(e.addr));
        check("wr_data", avm_writedata, e.data);
      end
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic issue(input logic fill, input logic [11:0] src, input logic [11:0] dst,
                       input int len, input logic [31:0] pat);
    logic [11:0] s, d;
    logic [31:0] v;
    int          k;
    k = 0;
    while (!cmd_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("ready_before_cmd", 32'(cmd_ready), 1);
    s = src & 12'hFFC;
    d = dst & 12'hFFC;
    for (int i = 0; i < len; i++) begin
      v = fill ? pat : ref_mem[s[11:2]];
      exp_q.push_back('{addr: d, data: v});
      ref_mem[d[11:2]] = v;
      s = s + 12'd4;
      d = d + 12'd4;
    end
    cmd_valid   = 1'b1;
    cmd_fill    = fill;
    cmd_src     = src;
    cmd_dst     = dst;
    cmd_len     = LEN_W'(len);
    cmd_pattern = pat;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busy_after_accept",  32'(busy), 1);
    check("ready_after_accept", 32'(cmd_ready), 0);
  endtask

  task automatic wait_done(input string tag, input int len, input int exp_cyc);
    int n;
    n = 1;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 32'(done), 1);
    check({tag, "_latency"}, n, exp_cyc);
    check({tag, "_words_done"}, 32'(words_done), len);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 32'(done), 0);
    check({tag, "_ready_back"}, 32'(cmd_ready), 1);
    check({tag, "_words_hold"}, 32'(words_done), len);
  endtask

  initial begin
    int base_rd, base_wr, base_rs, base_ws, d0, k;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    reset_n = 1'b0;
    cmd_valid = 1'b0; cmd_fill = 1'b0; cmd_src = '0; cmd_dst = '0;
    cmd_len = '0; cmd_pattern = '0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_words_done", 32'(words_done), 0);
    check("rst_read", 32'(avm_read), 0);
    check("rst_write", 32'(avm_write), 0);
    check("rst_address", 32'(avm_address), 0);
    check("rst_writedata", avm_writedata, 0);
    check("rst_byteenable", 32'(avm_byteenable), 32'hF);
    reset_n = 1'b1;
    @(negedge clk);

    issue(1'b1, 12'h000, 12'h010, 4, 32'hDEADBEEF);
    wait_done("fill4", 4, 5);

    issue(1'b0, 12'h000, 12'h100, 3, 32'h0);
    wait_done("copy3", 3, 10);
    check("copy3_m100", mem[12'h100 >> 2], 32'h11111111);
    check("copy3_m104", mem[12'h104 >> 2], 32'h22222222);
    check("copy3_m108", mem[12'h108 >> 2], 32'h33333333);

    base_rs = rd_stall_cyc;
    base_ws = wr_stall_cyc;
    stall_rd_at    = rd_total + 1;
    stall_rd_until = rd_stall_cyc + 3;
    stall_wr_at    = wr_total;
    stall_wr_until = wr_stall_cyc + 2;
    issue(1'b0, 12'h000, 12'h140, 3, 32'h0);
    wait_done("stall", 3, 15);
    check("stall_rd_cycles", rd_stall_cyc - base_rs, 3);
    check("stall_wr_cycles", wr_stall_cyc - base_ws, 2);
    check("stall_m140", mem[12'h140 >> 2], 32'h11111111);
    check("stall_m144", mem[12'h144 >> 2], 32'h22222222);
    check("stall_m148", mem[12'h148 >> 2], 32'h33333333);
    stall_rd_at = -1;
    stall_wr_at = -1;

    base_rd = rd_total;
    base_wr = wr_total;
    issue(1'b0, 12'h020, 12'h180, 0, 32'h0);
    wait_done("len0", 0, 1);
    check("len0_no_reads", rd_total, base_rd);
    check("len0_no_writes", wr_total, base_wr);

    issue(1'b1, 12'h000, 12'hFFC, 2, 32'hCAFEF00D);
    wait_done("wrap", 2, 3);
    check("wrap_mFFC", mem[12'hFFC >> 2], 32'hCAFEF00D);
    check("wrap_m000", mem[0], 32'hCAFEF00D);
    ref_mem[0] = 32'hCAFEF00D;

    issue(1'b1, 12'h000, 12'h013, 1, 32'h13579BDF);
    wait_done("unaligned", 1, 2);

    base_rd = rd_total;
    issue(1'b0, 12'h004, 12'h200, 3, 32'h0);
    k = 0;
    while (!(avm_read && rd_total == base_rd + 1) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("rst_mid_reached", 32'(avm_read), 1);
    #1;
    d0 = done_cnt;
    reset_n = 1'b0;
    #1;
    check("rst_mid_read", 32'(avm_read), 0);
    check("rst_mid_write", 32'(avm_write), 0);
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_ready", 32'(cmd_ready), 1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_mid_no_done", done_cnt, d0);
    check("rst_mid_ready_after", 32'(cmd_ready), 1);

    issue(1'b0, 12'h004, 12'h300, 2, 32'h0);
    wait_done("post_rst", 2, 7);
    check("post_rst_m300", mem[12'h300 >> 2], 32'h22222222);
    check("post_rst_m304", mem[12'h304 >> 2], 32'h33333333);

    repeat (3) @(negedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);
    check("done_total", done_cnt, 7);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tarea1_mem_copy_master.md
Name: tarea1_mem_copy_master

Overview:
Avalon-MM master engine that drives the 32-bit on-chip memory slave from the initiator side. It accepts one command at a time and either copies a block of words from a source address to a destination address, or fills a block with a constant pattern. It sits between a control register block or CPU-side command port and the system interconnect. It is the requester counterpart of the single-port on-chip RAM.

Parameters:
ADDR_W, 12, byte-address width on the Avalon master (1024 words x 4 bytes)
DATA_W, 32, Avalon data width; byteenable width is DATA_W/8
LEN_W, 11, width of the word-count field (max 1024 words)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  engine idle and able to accept a command
cmd_fill  in  1  1 = fill with cmd_pattern, 0 = copy
cmd_src  in  ADDR_W  source byte address (copy only)
cmd_dst  in  ADDR_W  destination byte address
cmd_len  in  LEN_W  number of 32-bit words
cmd_pattern  in  DATA_W  fill value
busy  out  1  transfer in progress
done  out  1  one-cycle pulse when a command completes
words_done  out  LEN_W  words written so far in the current or last command
avm_address  out  ADDR_W  byte address, word aligned
avm_read  out  1  read request
avm_write  out  1  write request
avm_writedata  out  DATA_W  write data
avm_byteenable  out  DATA_W/8  always all ones
avm_waitrequest  in  1  slave or fabric stall
avm_readdata  in  DATA_W  read data
avm_readdatavalid  in  1  read data strobe

Behaviour:
- Reset (asynchronous, reset_n=0): state IDLE.
  - cmd_ready=1, busy=0, done=0, words_done=0.
  - avm_read=0, avm_write=0, avm_address=0, avm_writedata=0.
  - avm_byteenable is constant all-ones.
- Handshake: a command is accepted on a rising edge when cmd_valid & cmd_ready.
  - The command fields are registered at acceptance.
  - cmd_ready=0 in every state except IDLE; commands presented while busy are ignored and held by the source.
- Addresses: bits [1:0] of cmd_src and cmd_dst are forced to 0.
  - Pointers advance by 4 after each accepted access.
  - Pointers wrap modulo 2^ADDR_W without error.
- FSM states:
  - IDLE
  - RD_REQ: avm_read=1, avm_address=src_ptr.
  - RD_WAIT: no request; waits for avm_readdatavalid.
  - WR_REQ: avm_write=1, avm_address=dst_ptr, writedata from the registered read data or from the pattern.
  - DONE
- Transitions:
  - IDLE -> DONE when the accepted cmd_len=0. No bus traffic is generated.
  - IDLE -> RD_REQ for copy; IDLE -> WR_REQ for fill.
  - RD_REQ -> RD_WAIT when avm_read & ~avm_waitrequest.
  - If avm_readdatavalid is seen in the same cycle the read is accepted, go directly to WR_REQ.
  - RD_WAIT -> WR_REQ on avm_readdatavalid; avm_readdata is captured into the write-data register.
  - WR_REQ, on write acceptance (~avm_waitrequest):
    - words_done increments.
    - If this was the last word, go to DONE.
    - Otherwise go to RD_REQ for copy, or stay in WR_REQ for fill with the next address.
  - DONE -> IDLE unconditionally. done=1 for exactly this one cycle.
- Avalon rules:
  - While avm_waitrequest=1, address, read, write and writedata hold stable.
  - avm_read and avm_write are never high together.
  - At most one read is outstanding.
  - A readdatavalid arriving in any state other than RD_REQ or RD_WAIT is ignored.
- Throughput with zero waitrequest and read latency 1:
  - Copy: 3 cycles per word (RD_REQ, RD_WAIT, WR_REQ).
  - Fill: 1 write per cycle.
- busy=1 from the cycle after acceptance through the DONE cycle.
- words_done clears to 0 at acceptance and holds its final value after DONE.
- Overlapping src/dst ranges are copied in ascending address order with no hazard protection. The result is defined by that order.
- Reset asserted mid-transfer:
  - The transfer is abandoned and all outputs take their reset values immediately.
  - No done pulse is produced.

Decomposition:
- Shared package tarea1_mem_pkg holds:
  - the FSM state enum;
  - constants WORD_BYTES=4 and BE_ALL=4'hF;
  - the command struct (fill, src, dst, len, pattern).
- No sub-module. The FSM, address counters and data register live in one module.

Test Plan:
- Fill: dst=0x010, len=4, pattern=0xDEADBEEF, waitrequest=0.
  -> 4 consecutive write cycles at 0x010, 0x014, 0x018, 0x01C; done pulses the cycle after the last write; words_done=4.
- Copy against an on-chip RAM model preloaded with words 0x11111111..0x33333333 at 0x000..0x008: src=0x000, dst=0x100, len=3.
  -> RAM 0x100..0x108 equals the source; 9 bus cycles; done pulse once.
- waitrequest=1 for 3 cycles on the 2nd read and 2 cycles on the 1st write.
  -> address, read, write and writedata hold stable during the stalls; the final memory contents match.
- cmd_len=0.
  -> no avm_read or avm_write; done one cycle after acceptance; cmd_ready returns the following cycle.
- Fill with dst=0xFFC, len=2.
  -> writes go to 0xFFC then 0x000 (wrap).
- Unaligned dst=0x013.
  -> first write goes to 0x010.
- Reset_n pulsed low during the 2nd word of a copy.
  -> read, write and busy drop asynchronously; no done pulse; cmd_ready=1 after release; a new command completes correctly.
